// File: rtl/neureka_pe_weight_accumulator.sv
// Shift-accumulates QW signed bit-plane partial results from the binconv PE into one
// full-precision result, negating the MSB plane for signed weights, on a registered valid/ready output.
module neureka_pe_weight_accumulator #(
  parameter int unsigned PRES_W = 22,
  parameter int unsigned QW_MAX = 8,
  parameter int unsigned ACC_W  = PRES_W + QW_MAX + 1,
  parameter int unsigned IDX_W  = (QW_MAX > 1) ? $clog2(QW_MAX) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [3:0]        ctrl_qw_i,
  input  logic              ctrl_signed_i,
  input  logic              pres_valid_i,
  output logic              pres_ready_o,
  input  logic [PRES_W-1:0] pres_data_i,
  output logic              sum_valid_o,
  input  logic              sum_ready_i,
  output logic [ACC_W-1:0]  sum_data_o,
  output logic [IDX_W-1:0]  bit_idx_o
);

  localparam logic [3:0] QW_MAX_L = 4'(QW_MAX);
  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [ACC_W-1:0] r_acc;
  logic [IDX_W-1:0] r_bit_cnt;
  logic [3:0]       r_qw;
  logic             r_signed;
  logic [0:0]       r_state;
  logic [ACC_W-1:0] r_sum_data;

  logic             w_first;
  logic [3:0]       w_qw_sat;
  logic [3:0]       w_qw_eff;
  logic             w_signed_eff;
  logic             w_last;
  logic             w_accept;
  logic             w_drain;
  logic [ACC_W-1:0] w_pres_ext;
  logic [ACC_W-1:0] w_term;
  logic [ACC_W-1:0] w_sum;

  function automatic logic [3:0] sat_qw(input logic [3:0] q);
    if (q == 4'd0)     return 4'd1;
    if (q > QW_MAX_L)  return QW_MAX_L;
    return q;
  endfunction

  // The first beat of a group decides its own length and sign from the live control inputs.
  assign w_first      = (r_bit_cnt == '0);
  assign w_qw_sat     = sat_qw(ctrl_qw_i);
  assign w_qw_eff     = w_first ? w_qw_sat : r_qw;
  assign w_signed_eff = w_first ? ctrl_signed_i : r_signed;
  assign w_last       = (4'(r_bit_cnt) == (w_qw_eff - 4'd1));

  assign sum_valid_o  = (r_state == ST_FULL);
  assign pres_ready_o = ~clear_i & (~w_last | ~sum_valid_o | sum_ready_i);
  assign w_accept     = pres_valid_i & pres_ready_o;
  assign w_drain      = sum_valid_o & sum_ready_i;

  assign w_pres_ext = {{(ACC_W-PRES_W){pres_data_i[PRES_W-1]}}, pres_data_i};
  assign w_term     = enable_i ? (w_pres_ext << r_bit_cnt) : '0;
  assign w_sum      = (w_signed_eff & w_last) ? (r_acc - w_term) : (r_acc + w_term);

  assign sum_data_o = r_sum_data;
  assign bit_idx_o  = r_bit_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc      <= '0;
      r_bit_cnt  <= '0;
      r_qw       <= 4'd1;
      r_signed   <= 1'b0;
      r_state    <= ST_ACCUM;
      r_sum_data <= '0;
    end else if (clear_i) begin
      r_acc      <= '0;
      r_bit_cnt  <= '0;
      r_qw       <= 4'd1;
      r_signed   <= 1'b0;
      r_state    <= ST_ACCUM;
      r_sum_data <= '0;
    end else begin
      // NOTE: non-blocking updates let the later load override the drain, so drain+load keeps FULL.
      if (w_drain) r_state <= ST_ACCUM;
      if (w_accept) begin
        if (w_first) begin
          r_qw     <= w_qw_sat;
          r_signed <= ctrl_signed_i;
        end
        if (w_last) begin
          r_sum_data <= w_sum;
          r_state    <= ST_FULL;
          r_acc      <= '0;
          r_bit_cnt  <= '0;
        end else begin
          r_acc     <= w_sum;
          r_bit_cnt <= r_bit_cnt + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_neureka_pe_weight_accumulator.sv
// Self-checking bench: directed vector table, hand-written backpressure/clear/reset sequences,
// and a randomized run against a plain-arithmetic reference model.
module tb_neureka_pe_weight_accumulator;

  localparam int PRES_W = 22;
  localparam int QW_MAX = 8;
  localparam int ACC_W  = PRES_W + QW_MAX + 1;
  localparam int IDX_W  = 3;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              enable;
  logic [3:0]        ctrl_qw;
  logic              ctrl_signed;
  logic              pres_valid;
  logic              pres_ready;
  logic [PRES_W-1:0] pres_data;
  logic              sum_valid;
  logic              sum_ready;
  logic [ACC_W-1:0]  sum_data;
  logic [IDX_W-1:0]  bit_idx;

  int n_checks = 0;
  int n_fail   = 0;

  neureka_pe_weight_accumulator #(.PRES_W(PRES_W), .QW_MAX(QW_MAX)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .enable_i     (enable),
    .ctrl_qw_i    (ctrl_qw),
    .ctrl_signed_i(ctrl_signed),
    .pres_valid_i (pres_valid),
    .pres_ready_o (pres_ready),
    .pres_data_i  (pres_data),
    .sum_valid_o  (sum_valid),
    .sum_ready_i  (sum_ready),
    .sum_data_o   (sum_data),
    .bit_idx_o    (bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int qw;
    bit sgn;
    bit en;
    int pres[8];
    int exp_sum;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int q);
    if (q == 0) return 1;
    if (q > QW_MAX) return QW_MAX;
    return q;
  endfunction

  // Weighted sum of the bit-planes: plane i weighs 2^i, the top plane weighs -2^(n-1) if signed.
  function automatic logic [ACC_W-1:0] ref_sum(input int n, input bit sgn,
                                               input int vals[8], input bit ens[8]);
    longint acc = 0;
    for (int i = 0; i < n; i++) begin
      longint v = ens[i] ? longint'(vals[i]) : 64'sd0;
      longint w = longint'(1) << i;
      if (sgn && i == n - 1) acc = acc - v * w;
      else                   acc = acc + v * w;
    end
    return acc[ACC_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    pres_valid = 1'b0;
    sum_ready  = 1'b1;
    tick();
  endtask

  // Drives one group back-to-back; control inputs are scrambled after the first beat.
  task automatic run_group(input int qw, input bit sgn, input bit en, input int pres[8],
                           input int exp_sum, input string name);
    int n = sat(qw);
    sum_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      pres_valid  = 1'b1;
      pres_data   = PRES_W'(pres[i]);
      enable      = en;
      ctrl_qw     = (i == 0) ? 4'(qw) : 4'($urandom);
      ctrl_signed = (i == 0) ? sgn : 1'($urandom);
      @(negedge clk);
      check({name, "_ready"}, longint'(pres_ready), 1);
      tick();
    end
    pres_valid = 1'b0;
    #1;
    check({name, "_valid"}, longint'(sum_valid), 1);
    check({name, "_data"}, longint'($signed(sum_data)), longint'(exp_sum));
    check({name, "_idx"}, longint'(bit_idx), 0);
  endtask

  task automatic beat(input int data);
    pres_valid = 1'b1;
    pres_data  = PRES_W'(data);
  endtask

  logic [ACC_W-1:0] exp_q[$];
  int               g_idx;
  int               g_n;
  bit               g_sgn;
  int               g_vals[8];
  bit               g_ens[8];
  bit               m_valid;

  initial begin
    vecs[0]  = '{qw: 4,  sgn: 0, en: 1, pres: '{3, 1, 0, 2, 0, 0, 0, 0}, exp_sum: 21};
    vecs[1]  = '{qw: 4,  sgn: 1, en: 1, pres: '{1, 0, 0, 1, 0, 0, 0, 0}, exp_sum: -7};
    vecs[2]  = '{qw: 4,  sgn: 1, en: 1, pres: '{-1, -1, -1, -1, 0, 0, 0, 0}, exp_sum: 1};
    vecs[3]  = '{qw: 0,  sgn: 1, en: 1, pres: '{-5, 0, 0, 0, 0, 0, 0, 0}, exp_sum: 5};
    vecs[4]  = '{qw: 4,  sgn: 0, en: 0, pres: '{5, 6, 7, 8, 0, 0, 0, 0}, exp_sum: 0};
    vecs[5]  = '{qw: 8,  sgn: 0, en: 1, pres: '{1, 1, 1, 1, 1, 1, 1, 1}, exp_sum: 255};
    vecs[6]  = '{qw: 15, sgn: 1, en: 1, pres: '{1, 1, 1, 1, 1, 1, 1, 1}, exp_sum: -1};
    vecs[7]  = '{qw: 2,  sgn: 0, en: 1, pres: '{5, -3, 0, 0, 0, 0, 0, 0}, exp_sum: -1};
    vecs[8]  = '{qw: 3,  sgn: 1, en: 1, pres: '{2, 1, -1, 0, 0, 0, 0, 0}, exp_sum: 8};
    vecs[9]  = '{qw: 1,  sgn: 0, en: 1, pres: '{2097151, 0, 0, 0, 0, 0, 0, 0}, exp_sum: 2097151};
    vecs[10] = '{qw: 8,  sgn: 0, en: 1,
                 pres: '{-2097152, -2097152, -2097152, -2097152, -2097152, -2097152, -2097152, -2097152},
                 exp_sum: -534773760};
    vecs[11] = '{qw: 8,  sgn: 1, en: 1,
                 pres: '{2097151, 2097151, 2097151, 2097151, 2097151, 2097151, 2097151, 2097151},
                 exp_sum: -2097151};
    vecs[12] = '{qw: 1,  sgn: 1, en: 1, pres: '{3, 0, 0, 0, 0, 0, 0, 0}, exp_sum: -3};

    // NOTE: inputs change 1 time unit after the rising edge so the DUT never samples a racing value.
    rst_n       = 1'b0;
    clear       = 1'b0;
    enable      = 1'b1;
    ctrl_qw     = 4'($urandom);
    ctrl_signed = 1'($urandom);
    pres_valid  = 1'($urandom);
    pres_data   = PRES_W'($urandom);
    sum_ready   = 1'($urandom);
    repeat (3) begin
      tick();
      pres_valid = 1'($urandom);
      pres_data  = PRES_W'($urandom);
    end
    check("rst_valid", longint'(sum_valid), 0);
    check("rst_data", longint'(sum_data), 0);
    check("rst_idx", longint'(bit_idx), 0);
    rst_n      = 1'b1;
    pres_valid = 1'b0;
    sum_ready  = 1'b1;
    tick();
    check("rst_ready", longint'(pres_ready), 1);
    check("rst_valid_post", longint'(sum_valid), 0);

    for (int v = 0; v < 13; v++)
      run_group(vecs[v].qw, vecs[v].sgn, vecs[v].en, vecs[v].pres, vecs[v].exp_sum,
                $sformatf("vec%0d", v));
    idle_cycle();
    #1;
    check("vec_drained", longint'(sum_valid), 0);

    // Backpressure, qw=2: second group's last beat stalls, then drain+load in one cycle.
    sum_ready = 1'b0; ctrl_qw = 4'd2; ctrl_signed = 1'b0; enable = 1'b1;
    beat(1); tick();
    beat(2); tick();
    #1;
    check("bp_valid_a", longint'(sum_valid), 1);
    check("bp_data_a", longint'($signed(sum_data)), 5);
    beat(3); #1;
    check("bp_first_ready", longint'(pres_ready), 1);
    tick();
    check("bp_idx", longint'(bit_idx), 1);
    beat(4); #1;
    for (int c = 0; c < 2; c++) begin
      check("bp_last_stall", longint'(pres_ready), 0);
      check("bp_hold_valid", longint'(sum_valid), 1);
      check("bp_hold_data", longint'($signed(sum_data)), 5);
      tick();
    end
    sum_ready = 1'b1; #1;
    check("bp_release_ready", longint'(pres_ready), 1);
    tick();
    pres_valid = 1'b0; #1;
    check("bp_swap_valid", longint'(sum_valid), 1);
    check("bp_swap_data", longint'($signed(sum_data)), 11);
    tick();
    check("bp_drained", longint'(sum_valid), 0);

    // Clear mid-group (qw=8, three beats), then a fresh full group.
    ctrl_qw = 4'd8; ctrl_signed = 1'b0;
    for (int b = 0; b < 3; b++) begin beat(7); tick(); end
    check("clr_idx_pre", longint'(bit_idx), 3);
    clear = 1'b1; #1;
    check("clr_ready", longint'(pres_ready), 0);
    tick();
    clear = 1'b0; pres_valid = 1'b0; #1;
    check("clr_idx", longint'(bit_idx), 0);
    check("clr_valid", longint'(sum_valid), 0);
    check("clr_data", longint'(sum_data), 0);
    run_group(8, 0, 1, vecs[5].pres, 255, "clr_next");
    idle_cycle();

    // Asynchronous reset mid-group discards the partial group.
    ctrl_qw = 4'd4; ctrl_signed = 1'b1;
    beat(9); tick();
    beat(9); tick();
    pres_valid = 1'b0;
    rst_n = 1'b0; #2;
    check("mid_rst_idx", longint'(bit_idx), 0);
    check("mid_rst_valid", longint'(sum_valid), 0);
    rst_n = 1'b1;
    tick(); tick();
    check("mid_rst_no_out", longint'(sum_valid), 0);
    run_group(4, 0, 1, vecs[0].pres, 21, "post_rst");
    idle_cycle();

    // Randomized traffic against the reference model.
    g_idx = 0; g_n = 1; g_sgn = 1'b0; m_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bit exp_last, exp_ready, acc, drain;
      pres_valid  = ($urandom_range(0, 3) != 0);
      pres_data   = PRES_W'($urandom);
      enable      = ($urandom_range(0, 4) != 0);
      ctrl_qw     = 4'($urandom);
      ctrl_signed = 1'($urandom);
      sum_ready   = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      exp_last  = (g_idx == 0) ? (sat(int'(ctrl_qw)) == 1) : (g_idx == g_n - 1);
      exp_ready = !exp_last || !m_valid || sum_ready;
      check("rand_valid", longint'(sum_valid), longint'(m_valid));
      check("rand_ready", longint'(pres_ready), longint'(exp_ready));
      if (m_valid) begin
        if (exp_q.size() == 0) check("rand_queue", 1, 0);
        else check("rand_data", longint'($signed(sum_data)), longint'($signed(exp_q[0])));
      end
      drain = m_valid && sum_ready;
      if (drain && exp_q.size() != 0) void'(exp_q.pop_front());
      acc = pres_valid && exp_ready;
      if (acc) begin
        if (g_idx == 0) begin
          g_n   = sat(int'(ctrl_qw));
          g_sgn = ctrl_signed;
        end
        g_vals[g_idx] = int'($signed(pres_data));
        g_ens[g_idx]  = enable;
        g_idx++;
        if (g_idx == g_n) begin
          exp_q.push_back(ref_sum(g_n, g_sgn, g_vals, g_ens));
          g_idx = 0;
        end
      end
      m_valid = (acc && exp_last) ? 1'b1 : (drain ? 1'b0 : m_valid);
      tick();
    end
    pres_valid = 1'b0;
    sum_ready  = 1'b1;
    @(negedge clk);
    if (m_valid) begin
      check("final_valid", longint'(sum_valid), 1);
      if (exp_q.size() != 0)
        check("final_data", longint'($signed(sum_data)), longint'($signed(exp_q[0])));
    end
    tick();
    check("final_drained", longint'(sum_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
